// File: rtl/button_debounce_pulse.sv
// button_debounce_pulse: synchronized, debounced button with one-cycle press pulse and optional auto-repeat
module button_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 15000000
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic buttonPulse,
   output logic buttonLevel,
   output logic repeatActive
);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(RPT_MAX + 1);
   localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE} state_t;

   state_t state, stateNext;
   logic syncMeta, btnSync;
   logic [DW-1:0] debCnt, debNext;
   logic [RW-1:0] rptCnt, rptNext;
   logic pulseNext, levelNext, repeatNext;

   // two-flop synchronizer for the raw asynchronous button
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncMeta <= 1'b0;
         btnSync  <= 1'b0;
      end else begin
         syncMeta <= button;
         btnSync  <= syncMeta;
      end
   end

   // state, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         debCnt       <= '0;
         rptCnt       <= '0;
         buttonPulse  <= 1'b0;
         buttonLevel  <= 1'b0;
         repeatActive <= 1'b0;
      end else begin
         state        <= stateNext;
         debCnt       <= debNext;
         rptCnt       <= rptNext;
         buttonPulse  <= pulseNext;
         buttonLevel  <= levelNext;
         repeatActive <= repeatNext;
      end
   end

   // next-state, counter and output decisions; pulses only on accepted press or repeat
   always_comb begin
      stateNext = state;
      debNext   = debCnt;
      rptNext   = rptCnt;
      pulseNext = 1'b0;
      levelNext = buttonLevel;
      case (state)
         IDLE: begin
            levelNext = 1'b0;
            if (btnSync) begin
               stateNext = DEB_PRESS;
               debNext   = '0;
            end
         end
         DEB_PRESS: begin
            if (!btnSync) stateNext = IDLE;
            else if (debCnt == DEB_LAST) begin
               stateNext = HELD;
               rptNext   = '0;
               pulseNext = 1'b1;
               levelNext = 1'b1;
            end else debNext = debCnt + 1'b1;
         end
         HELD: begin
            if (!btnSync) begin
               stateNext = DEB_RELEASE;
               debNext   = '0;
            end else if (REPEAT_EN != 0) begin
               if (rptCnt == DELAY_LAST) begin
                  stateNext = REPEAT;
                  rptNext   = '0;
                  pulseNext = 1'b1;
               end else rptNext = rptCnt + 1'b1;
            end
         end
         REPEAT: begin
            if (!btnSync) begin
               stateNext = DEB_RELEASE;
               debNext   = '0;
            end else if (rptCnt == PERIOD_LAST) begin
               rptNext   = '0;
               pulseNext = 1'b1;
            end else rptNext = rptCnt + 1'b1;
         end
         DEB_RELEASE: begin
            if (btnSync) begin
               stateNext = HELD;
               rptNext   = '0;
            end else if (debCnt == DEB_LAST) begin
               stateNext = IDLE;
               levelNext = 1'b0;
            end else debNext = debCnt + 1'b1;
         end
         default: stateNext = IDLE;
      endcase
      repeatNext = (stateNext == REPEAT);
   end
endmodule

// File: doc/button_debounce_pulse.md
BUTTON_DEBOUNCE_PULSE -- requirements
Module: button_debounce_pulse

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive synchronized-stable cycles needed to accept a press or release (legal range >=1).
REQ-002 SHALL have parameter REPEAT_EN, default 1, 1 = auto-repeat while held, 0 = single pulse per press.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000, held cycles after the press pulse before the first repeat pulse (legal range >=2).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 15000000, cycles between repeat pulses (legal range >=2).
REQ-005 SHALL have port clk  input  1  system clock; all sequential logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port button  input  1  raw, asynchronous, bouncing button level, active-high.
REQ-008 SHALL have port buttonPulse  output  1  one-cycle pulse per accepted press and per repeat.
REQ-009 SHALL have port buttonLevel  output  1  debounced button level.
REQ-010 SHALL have port repeatActive  output  1  high while the block is in REPEAT.

Function
REQ-011 SHALL pass button through a 2-flop synchronizer (btnSync); only btnSync feeds the FSM.
REQ-012 SHALL implement FSM states IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE with one shared debounce counter and one repeat counter, each sized by $clog2 of its largest parameter.
REQ-013 IDLE: buttonLevel=0; btnSync=1 -> DEB_PRESS with debounce counter cleared.
REQ-014 DEB_PRESS: btnSync=0 -> IDLE, no pulse (glitch rejected); btnSync=1 for DEBOUNCE_CYCLES consecutive cycles -> HELD, buttonLevel=1, buttonPulse=1 for exactly one cycle.
REQ-015 Latency: if E0 is the first edge sampling button=1 and button then stays stable, buttonPulse and buttonLevel SHALL rise in the cycle after edge E0+DEBOUNCE_CYCLES+2.
REQ-016 HELD: repeat counter counts from 0 on entry; REPEAT_EN=1 and count reaches REPEAT_DELAY -> REPEAT with one buttonPulse; REPEAT_EN=0 -> remain HELD indefinitely.
REQ-017 REPEAT: repeatActive=1; buttonPulse for one cycle every REPEAT_PERIOD cycles, counter wraps to 0 at each pulse.
REQ-018 HELD or REPEAT with btnSync=0 -> DEB_RELEASE, debounce counter cleared, no pulse; buttonLevel stays 1.
REQ-019 DEB_RELEASE: btnSync=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE, buttonLevel=0; btnSync=1 before that -> HELD with repeat counter cleared, no pulse, repeatActive=0.
REQ-020 Release SHALL never generate buttonPulse; buttonPulse SHALL never be high on two consecutive cycles.
REQ-021 All outputs SHALL be registered (no combinational path from button to any output).

Reset
REQ-022 reset high SHALL asynchronously force synchronizer flops, counters, buttonPulse, buttonLevel, repeatActive to 0 and state to IDLE.
REQ-023 Reset asserted mid-debounce, mid-hold or mid-repeat SHALL abort with no pulse; a button still held at reset deassertion SHALL be treated as a new press (full debounce, then one pulse).
REQ-024 Deassertion is synchronous to clk externally; no pulse SHALL appear in the first DEBOUNCE_CYCLES+2 cycles after reset release.

Verification (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, REPEAT_EN=1)
REQ-025 Clean press: button 0->1 sampled at edge E0, held 10 cycles -> single buttonPulse in cycle after E0+6, buttonLevel=1 from same cycle, no further pulse.
REQ-026 Bounce: button toggles 1,0,1,0 each cycle then stable 1 -> exactly one buttonPulse, 6 cycles after the last transition's sampling edge; toggles then stable 0 -> no pulse.
REQ-027 Auto-repeat: hold 60 cycles after press pulse -> repeat pulses at +20, +25, +30 ... cycles after press pulse, repeatActive=1 from first repeat, 9 repeat pulses total.
REQ-028 Release glitch: in HELD drop button for 2 cycles then restore -> no pulse, buttonLevel stays 1, repeat restarts with REPEAT_DELAY timing.
REQ-029 REPEAT_EN=0 build: hold 100 cycles -> exactly one pulse, repeatActive always 0.
REQ-030 Reset mid-repeat: assert reset asynchronously between clock edges during REPEAT with button held -> all outputs 0 immediately; after release, one pulse 6 cycles after first sampling edge.
